// File: rtl/battle_turn_scheduler.sv
// Turn sequencer for BruteForce: alternates player/CPU attacks, resolves outcomes via LFSR, owns both health bars.
// Optional BF_CRIT_EN: player hits become critical (double damage) when lfsr[15:13] == 3'b111.
module battle_turn_scheduler #(
    parameter int unsigned THINK_CYCLES = 100_000_000,
    parameter logic [15:0] LFSR_SEED    = 16'hACE1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       key_valid,
    input  logic [3:0] key_code,
    output logic [9:0] p_health,
    output logic [9:0] c_health,
    output logic       player_turn,
    output logic       game_over,
    output logic       player_won,
    output logic [1:0] last_hit
);
    localparam int unsigned CNT_W = (THINK_CYCLES > 1) ? $clog2(THINK_CYCLES) : 1;
    localparam int unsigned DMG_W = 3;

    typedef enum logic [2:0] {P_WAIT, P_APPLY, C_THINK, C_APPLY, OVER} state_t;

    state_t             state_q, state_d;
    logic [15:0]        lfsr_q, lfsr_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               block_q, block_d;
    logic [DMG_W-1:0]   dmg_q, dmg_d;
    logic [1:0]         hit_q, hit_d;
    logic [9:0]         p_health_d, c_health_d;
    logic               player_turn_d, game_over_d, player_won_d;
    logic [1:0]         last_hit_d;
    logic [9:0]         hp_new;
    logic [DMG_W-1:0]   cpu_dmg;

    // Next-state and next-output logic; the player's outcome is latched in P_WAIT and applied in P_APPLY
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        block_d       = block_q;
        dmg_d         = dmg_q;
        hit_d         = hit_q;
        p_health_d    = p_health;
        c_health_d    = c_health;
        player_turn_d = player_turn;
        game_over_d   = game_over;
        player_won_d  = player_won;
        last_hit_d    = last_hit;
        hp_new        = '0;
        cpu_dmg       = '0;
        lfsr_d        = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);

        case (state_q)
            P_WAIT: begin
                if (key_valid) begin
                    case (key_code)
                        4'd1: begin
                            dmg_d         = DMG_W'(1);
                            hit_d         = 2'b01;
`ifdef BF_CRIT_EN
                            if (lfsr_q[15:13] == 3'b111) begin
                                dmg_d = DMG_W'(2);
                                hit_d = 2'b10;
                            end
`endif
                            state_d       = P_APPLY;
                            player_turn_d = 1'b0;
                        end
                        4'd2: begin
                            if (lfsr_q[0]) begin
                                dmg_d = DMG_W'(2);
                                hit_d = 2'b01;
`ifdef BF_CRIT_EN
                                if (lfsr_q[15:13] == 3'b111) begin
                                    dmg_d = DMG_W'(4);
                                    hit_d = 2'b10;
                                end
`endif
                            end else begin
                                dmg_d = DMG_W'(0);
                                hit_d = 2'b11;
                            end
                            state_d       = P_APPLY;
                            player_turn_d = 1'b0;
                        end
                        4'd3: begin
                            dmg_d         = DMG_W'(0);
                            hit_d         = 2'b00;
                            block_d       = 1'b1;
                            state_d       = P_APPLY;
                            player_turn_d = 1'b0;
                        end
                        default: ;
                    endcase
                end
            end
            P_APPLY: begin
                hp_new     = c_health << dmg_q;
                c_health_d = hp_new;
                last_hit_d = hit_q;
                if (hp_new == 10'd0) begin
                    state_d      = OVER;
                    game_over_d  = 1'b1;
                    player_won_d = 1'b1;
                end else begin
                    cnt_d   = CNT_W'(THINK_CYCLES - 1);
                    state_d = C_THINK;
                end
            end
            C_THINK: begin
                if (cnt_q == '0) state_d = C_APPLY;
                else             cnt_d   = cnt_q - CNT_W'(1);
            end
            C_APPLY: begin
                case (lfsr_q[1:0])
                    2'b00:   begin cpu_dmg = DMG_W'(0); last_hit_d = 2'b11; end
                    2'b11:   begin cpu_dmg = DMG_W'(2); last_hit_d = 2'b01; end
                    default: begin cpu_dmg = DMG_W'(1); last_hit_d = 2'b01; end
                endcase
                // A raised block absorbs one point of the CPU hit
                if (block_q && cpu_dmg != '0) cpu_dmg = cpu_dmg - DMG_W'(1);
                block_d    = 1'b0;
                hp_new     = p_health << cpu_dmg;
                p_health_d = hp_new;
                if (hp_new == 10'd0) begin
                    state_d      = OVER;
                    game_over_d  = 1'b1;
                    player_won_d = 1'b0;
                end else begin
                    state_d       = P_WAIT;
                    player_turn_d = 1'b1;
                end
            end
            OVER: ;
            default: state_d = P_WAIT;
        endcase
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= P_WAIT;
            lfsr_q      <= LFSR_SEED;
            cnt_q       <= '0;
            block_q     <= 1'b0;
            dmg_q       <= '0;
            hit_q       <= 2'b00;
            p_health    <= 10'h3FF;
            c_health    <= 10'h3FF;
            player_turn <= 1'b1;
            game_over   <= 1'b0;
            player_won  <= 1'b0;
            last_hit    <= 2'b00;
        end else begin
            state_q     <= state_d;
            lfsr_q      <= lfsr_d;
            cnt_q       <= cnt_d;
            block_q     <= block_d;
            dmg_q       <= dmg_d;
            hit_q       <= hit_d;
            p_health    <= p_health_d;
            c_health    <= c_health_d;
            player_turn <= player_turn_d;
            game_over   <= game_over_d;
            player_won  <= player_won_d;
            last_hit    <= last_hit_d;
        end
    end
endmodule

// File: tb/tb_battle_turn_scheduler.sv
// Self-checking bench for battle_turn_scheduler: vector table, hand sequences and random turns
// against a health-count reference model.
module tb_battle_turn_scheduler;
    localparam int unsigned T    = 4;
    localparam logic [15:0] SEED = 16'hACE1;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       key_valid = 1'b0;
    logic [3:0] key_code = 4'd0;
    logic [9:0] p_health, c_health;
    logic       player_turn, game_over, player_won;
    logic [1:0] last_hit;

    battle_turn_scheduler #(.THINK_CYCLES(T), .LFSR_SEED(SEED)) dut (
        .clk(clk), .reset(reset), .key_valid(key_valid), .key_code(key_code),
        .p_health(p_health), .c_health(c_health), .player_turn(player_turn),
        .game_over(game_over), .player_won(player_won), .last_hit(last_hit)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: health as a count of remaining bars
    logic [15:0] m_lfsr;
    int          m_p, m_c;
    logic [1:0]  m_hit;
    logic        m_block, m_over, m_won;

    function automatic logic [15:0] lfsr_step(input logic [15:0] s);
        logic fb;
        fb = s[0];
        s  = s >> 1;
        if (fb) s = s ^ 16'hB400;
        return s;
    endfunction

    always @(posedge clk) begin
        if (reset) m_lfsr <= SEED;
        else       m_lfsr <= lfsr_step(m_lfsr);
    end

    function automatic logic [9:0] therm(input int n);
        logic [19:0] t;
        t = 20'h3FF << (10 - n);
        return t[9:0];
    endfunction

    function automatic int sat_sub(input int a, input int b);
        return (a > b) ? a - b : 0;
    endfunction

    task automatic tick;
        @(negedge clk);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk_all(input string tag, input logic exp_turn);
        chk({tag, "_p_health"}, 32'(p_health), 32'(therm(m_p)));
        chk({tag, "_c_health"}, 32'(c_health), 32'(therm(m_c)));
        chk({tag, "_player_turn"}, 32'(player_turn), 32'(exp_turn));
        chk({tag, "_game_over"}, 32'(game_over), 32'(m_over));
        chk({tag, "_player_won"}, 32'(player_won), 32'(m_won));
        chk({tag, "_last_hit"}, 32'(last_hit), 32'(m_hit));
    endtask

    task automatic model_reset;
        m_p = 10; m_c = 10; m_hit = 2'b00; m_block = 1'b0; m_over = 1'b0; m_won = 1'b0;
    endtask

    task automatic do_reset;
        reset = 1'b1; key_valid = 1'b0;
        tick; tick;
        model_reset();
        chk_all("reset", 1'b1);
        reset = 1'b0;
    endtask

    // One key pulse in P_WAIT, followed through the full turn when accepted
    task automatic press(input logic [3:0] code);
        logic [15:0] l;
        int          pd, cd;
        logic [1:0]  ph;
        if (m_over) begin
            key_valid = 1'b1; key_code = code; tick; key_valid = 1'b0;
            tick; tick;
            chk_all("over_frozen", 1'b0);
            return;
        end
        if (code < 4'd1 || code > 4'd3) begin
            key_valid = 1'b1; key_code = code; tick; key_valid = 1'b0;
            chk_all("ignored_a", 1'b1);
            tick;
            chk_all("ignored_b", 1'b1);
            return;
        end
        l = m_lfsr;
        pd = 0; ph = 2'b00;
        if (code == 4'd1) begin pd = 1; ph = 2'b01; end
        else if (code == 4'd2) begin
            if (l[0]) begin pd = 2; ph = 2'b01; end
            else      begin pd = 0; ph = 2'b11; end
        end
`ifdef BF_CRIT_EN
        if (ph == 2'b01 && l[15:13] == 3'b111) begin pd = pd * 2; ph = 2'b10; end
`endif
        key_valid = 1'b1; key_code = code; tick; key_valid = 1'b0;
        chk("pturn_fall", 32'(player_turn), 32'd0);
        chk("c_not_yet", 32'(c_health), 32'(therm(m_c)));
        tick;
        m_c = sat_sub(m_c, pd);
        m_hit = ph;
        if (code == 4'd3) m_block = 1'b1;
        if (m_c == 0) begin m_over = 1'b1; m_won = 1'b1; end
        chk_all("player_apply", 1'b0);
        if (m_over) return;
        for (int i = 0; i < int'(T); i++) begin
            if (i == 1) begin key_valid = 1'b1; key_code = 4'd1; end
            chk("think_turn", 32'(player_turn), 32'd0);
            chk("think_c", 32'(c_health), 32'(therm(m_c)));
            tick;
            key_valid = 1'b0;
        end
        chk("capply_turn", 32'(player_turn), 32'd0);
        chk("capply_p", 32'(p_health), 32'(therm(m_p)));
        l = m_lfsr;
        case (l[1:0])
            2'b00:   begin cd = 0; ph = 2'b11; end
            2'b11:   begin cd = 2; ph = 2'b01; end
            default: begin cd = 1; ph = 2'b01; end
        endcase
        if (m_block) cd = sat_sub(cd, 1);
        tick;
        m_p = sat_sub(m_p, cd);
        m_hit = ph;
        m_block = 1'b0;
        if (m_p == 0) begin m_over = 1'b1; m_won = 1'b0; end
        chk_all("cpu_apply", !m_over);
    endtask

    typedef struct {
        logic [3:0] code;
        int         c_drop;
    } vec_t;

    vec_t vecs[10];

    initial begin
        int c_pre;
        logic over_pre;
        vecs[0] = '{4'd0, 0};  vecs[1] = '{4'd1, 1};  vecs[2] = '{4'd7, 0};
        vecs[3] = '{4'd3, 0};  vecs[4] = '{4'd4, 0};  vecs[5] = '{4'd15, 0};
        vecs[6] = '{4'd1, 1};  vecs[7] = '{4'd8, 0};  vecs[8] = '{4'd3, 0};
        vecs[9] = '{4'd1, 1};

        model_reset();
        do_reset();

        // Table of light/block/ignored keys with fixed CPU-bar outcomes
        for (int i = 0; i < 10; i++) begin
            c_pre = m_c; over_pre = m_over;
            press(vecs[i].code);
            if (!over_pre) chk("tbl_c_health", 32'(c_health), 32'(therm(sat_sub(c_pre, vecs[i].c_drop))));
        end

        // Reset wins over a simultaneous key strobe
        do_reset();
        reset = 1'b1; key_valid = 1'b1; key_code = 4'd1; tick;
        reset = 1'b0; key_valid = 1'b0;
        chk_all("reset_vs_key", 1'b1);
        tick;
        chk_all("reset_vs_key_next", 1'b1);

        // Reset during C_THINK cancels the pending CPU attack
        do_reset();
        key_valid = 1'b1; key_code = 4'd1; tick; key_valid = 1'b0;
        tick; tick;
        chk("midturn_in_think", 32'(player_turn), 32'd0);
        reset = 1'b1; tick; reset = 1'b0;
        model_reset();
        chk_all("midturn_reset", 1'b1);
        for (int i = 0; i < int'(T) + 4; i++) begin
            tick;
            chk_all("midturn_no_cpu", 1'b1);
        end

        // Block streak: CPU damage absorbed by one point each turn
        do_reset();
        for (int i = 0; i < 20; i++) begin
            if (m_over) do_reset();
            press(4'd3);
        end

        // Play light attacks to game over, then check the freeze and recovery
        do_reset();
        for (int i = 0; i < 40 && !m_over; i++) press(4'd1);
        chk("go_reached", 32'(game_over), 32'd1);
        press(4'd1);
        press(4'd2);
        press(4'd3);
        do_reset();

        // Random commands against the model
        for (int i = 0; i < 120; i++) begin
            logic [3:0] code;
            if (m_over && $urandom_range(0, 2) == 0) do_reset();
            case ($urandom_range(0, 5))
                0: code = 4'd1;
                1: code = 4'd2;
                2: code = 4'd3;
                default: code = 4'($urandom_range(0, 15));
            endcase
            press(code);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/battle_turn_scheduler.md
# battle_turn_scheduler

- Turn-based combat sequencer for the BruteForce game. It consumes decoded keyboard attack commands and alternates player and CPU turns.
- It resolves hit, miss and block outcomes with an internal LFSR and applies damage to both thermometer-coded health bars.
- It sits between the PS/2 key decoder (key code strobe) and the LED health display.
- It is the single owner of both health registers.

## Interface
Parameters:
- `THINK_CYCLES`, default 100_000_000: CPU delay in clocks between player resolution and CPU attack (1 s at 100 MHz). Must be ≥1.
- `LFSR_SEED`, default 16'hACE1: reset value of the random LFSR. Must be nonzero.

Ports:
- `clk`  in  1: system clock. Single clock domain.
- `reset`  in  1: synchronous, active-high reset.
- `key_valid`  in  1: one-cycle strobe, already synchronous to `clk`, marking a new key code.
- `key_code`  in  4: 4'b0001 light attack, 4'b0010 heavy attack, 4'b0011 block. All other codes are ignored.
- `p_health`  out  10: player health, thermometer-coded with ones in the MSBs.
- `c_health`  out  10: CPU health, same coding as `p_health`.
- `player_turn`  out  1: high while a player command is being accepted.
- `game_over`  out  1: high once either health reaches zero.
- `player_won`  out  1: valid when `game_over` is high. 1 means the CPU health reached zero.
- `last_hit`  out  2: result of the most recent attack. 00 none, 01 normal, 10 critical, 11 miss.

## Operation
Reset and general rules:
- Reset values: state P_WAIT; `p_health` = `c_health` = 10'h3FF; `player_turn` = 1; `game_over` = 0; `player_won` = 0; `last_hit` = 00; block flag = 0; LFSR = `LFSR_SEED`; think counter = 0.
- LFSR: 16-bit Galois, polynomial x^16+x^14+x^13+x^11+1. It advances every cycle, including while `game_over` is high; only `reset` stops it. Each decision uses the LFSR value registered in that same cycle.
- Damage application: health <= health << dmg, with zeros entering at the LSB. dmg ≥ 10 gives zero. Health is never incremented.

States:
- **P_WAIT**: `player_turn` = 1. Act only when `key_valid` is high; otherwise hold.
  - Code 1 (light): dmg = 1, `last_hit` = 01.
  - Code 2 (heavy): if lfsr[0] = 1, dmg = 2 and `last_hit` = 01; otherwise dmg = 0 and `last_hit` = 11.
  - Code 3 (block): dmg = 0, `last_hit` = 00, block flag set.
  - Codes 1, 2 and 3 move to P_APPLY. Any other code leaves state and outputs unchanged.
- **P_APPLY**: one cycle; `player_turn` = 0. Apply dmg to `c_health`.
  - If the new `c_health` is 0: go to OVER with `player_won` = 1.
  - Otherwise: load the think counter with `THINK_CYCLES` − 1 and go to C_THINK.
- **C_THINK**: decrement the counter; when it reads 0, go to C_APPLY. `key_valid` is ignored and dropped, not queued.
- **C_APPLY**: one cycle. Decode lfsr[1:0]:
  - 00: miss, dmg 0, `last_hit` = 11.
  - 01 or 10: dmg 1, `last_hit` = 01.
  - 11: dmg 2, `last_hit` = 01.
  - If the block flag is set, dmg = max(dmg − 1, 0).
  - Clear the block flag and apply dmg to `p_health`.
  - If the new `p_health` is 0: go to OVER with `player_won` = 0. Otherwise go to P_WAIT.
- **OVER**: `game_over` = 1; all outputs frozen. Only `reset` leaves this state.

Priorities:
- `reset` overrides everything, including a `key_valid` in the same cycle and any mid-turn state.
- The CPU is only evaluated after a surviving player turn, so both health bars can never reach zero together.

## Timing
- `key_valid` sampled at edge N in P_WAIT:
  - `player_turn` falls after edge N.
  - `c_health` and `last_hit` update after edge N+1.
- C_THINK lasts exactly `THINK_CYCLES` cycles.
- `p_health` updates after edge N+2+`THINK_CYCLES`. `player_turn` rises at the same time unless the game is over.
- `game_over` asserts in the same cycle as the health update that reaches zero.
- A second `key_valid` arriving less than `THINK_CYCLES`+3 cycles after the first is lost.
- All outputs are registered. There are no combinational paths from inputs to outputs.

## Configuration
- `BF_CRIT_EN` defined:
  - A player light or heavy attack that would hit becomes critical when lfsr[15:13] = 3'b111.
  - Critical damage is doubled: light = 2, heavy = 4, with `last_hit` = 10.
- `BF_CRIT_EN` undefined:
  - No critical logic is compiled.
  - `last_hit` never equals 10, and player damage never exceeds 2.

## Test plan
- **Reset values:** assert `reset` 2 cycles → `p_health` = `c_health` = 10'h3FF, `player_turn` = 1, `game_over` = 0, `last_hit` = 00.
- **Light attack and CPU turn:** `THINK_CYCLES` = 4; pulse code 1.
  - Without `BF_CRIT_EN`: `c_health` = 10'h3FE two edges after the pulse.
  - `player_turn` stays low for 6 cycles.
  - `p_health` then drops by 0, 1 or 2 positions, consistent with `last_hit`.
- **Ignored keys:** pulse code 4'b0111 in P_WAIT, then pulse code 1 during C_THINK → no state change, `c_health` unchanged, no extra turn.
- **Block:** code 3 → `c_health` unchanged, CPU damage ≤1. Repeat 20 turns with block → `p_health` never loses more than 1 bit per turn.
- **Game over:** repeated light attacks until `c_health` = 0 → `game_over` = 1, `player_won` = 1; later key pulses change nothing; `reset` restores 10'h3FF.
- **Reset mid-turn:** assert `reset` during C_THINK → next cycle matches the reset values and the pending CPU attack never occurs.
